coder_out_streamer: RTL
=======================

// Module: coder_out_streamer
// PURPOSE
//  Reader of the coder's wide result buses (pk_out, sk_out, c_out, m_out).
//  On a start pulse, captures the selected bus into an internal shift register.
//  Then emits it as a DATA_W-bit valid/ready stream, least-significant word first.
//  Sits between the coder and the host interface; the mirror of the wide-load path.
// PARAMETERS
//  DATA_W   32   stream word width; legal values 8, 16, 32, 64 (must divide 256)
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  start        in   1     1-cycle request; sampled only in IDLE
//  sel          in   2     0=pk (6400b), 1=sk (6144b), 2=c (6144b), 3=m (256b)
//  abort        in   1     drop the current transfer and return to IDLE
//  pk_out       in   6400  {t, rho} from the coder
//  sk_out       in   6144  encoded s from the coder
//  c_out        in   6144  {v, u} from the coder
//  m_out        in   256   message from the coder
//  tx_data      out  DATA_W  stream word
//  tx_valid     out  1     tx_data is valid
//  tx_ready     in   1     downstream accepts the word
//  tx_last      out  1     high with the final word of the frame
//  busy         out  1     high in any state other than IDLE
//  done         out  1     1-cycle pulse after the final handshake
// BEHAVIOUR
//  - Reset (synchronous, active-high):
//      - state=IDLE; tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0.
//      - Shift register and word counter are cleared.
//  - Words per frame N = bits(sel)/DATA_W. For DATA_W=32: pk=200, sk=192, c=192, m=8.
//  - Word counter is 10 bits wide (max 800 words at DATA_W=8).
//  - FSM states: IDLE, SEND, (CHK when the optional feature is enabled).
//  - IDLE, start=1 at cycle T:
//      - Capture the selected bus, zero-extended to 6400b, into the shift register.
//      - Load cnt=N-1; go to SEND.
//      - tx_valid=1 at T+1, with tx_data = bus[DATA_W-1:0].
//  - SEND: handshake = tx_valid & tx_ready.
//      - On handshake: shift register >>= DATA_W; cnt decrements; next word is presented the following cycle.
//      - Throughput is 1 word/cycle while tx_ready is held high.
//      - While tx_valid & !tx_ready: tx_data and tx_last hold stable.
//      - tx_last = (cnt==0).
//      - On the handshake of the last word: go to IDLE and drop tx_valid. done=1 for exactly one cycle, in the cycle after that handshake.
//  - start while busy is ignored; the captured data is never updated mid-frame.
//  - abort=1 (any state except IDLE):
//      - Next cycle: IDLE, tx_valid=0, tx_last=0; done is not pulsed.
//      - abort has priority over a handshake in the same cycle.
//      - abort in IDLE is a no-op.
//  - start and abort together in IDLE: abort wins; nothing is captured.
//  - rst mid-frame behaves like abort, plus all registers are cleared.
//  - A new start may arrive in the same cycle as done: it is accepted because the FSM is already in IDLE.
//  - tx_data is registered; no combinational path from tx_ready to tx_data or tx_valid.
// CONFIGURATION
//  CODER_STREAM_CHK_EN defined:
//      - A running XOR of all accepted data words is kept.
//      - After the last data word, the FSM enters CHK and emits one extra word, tx_data=XOR.
//      - tx_last moves from the last data word to the checksum word.
//      - done pulses after the checksum handshake. Frame length is N+1.
//      - abort in CHK behaves as in SEND.
//  CODER_STREAM_CHK_EN undefined:
//      - No CHK state and no XOR register; frame length is exactly N.
// TESTING
//  1. sel=3, m_out=256'h1F..00 (bytes 0x00..0x1F), tx_ready=1, DATA_W=32 -> 8 words, first 32'h03020100.
//     tx_last on word 7 (32'h1F1E1D1C); done 1 cycle later.
//  2. sel=0, pk_out with rho=256'hA5..A5, tx_ready=1 -> 200 words; words 0-7 = 32'hA5A5A5A5.
//     tx_last only on word 199; total frame 200 handshakes.
//  3. sel=2 with tx_ready toggled 1,0,0,1 pseudo-randomly -> tx_data and tx_last stable while stalled.
//     192 words in order; no duplicate or drop.
//  4. abort asserted at word 50 of an sk frame -> tx_valid=0 next cycle, no done.
//     A following start with sel=3 streams m correctly from word 0.
//  5. start pulsed again during a c frame; rst pulsed mid-frame -> second start ignored.
//     After rst, all outputs are 0 and busy=0 on the next cycle.
//  6. CHK_EN build, sel=3, m=all 0xFF -> 9 words; word 8 = 32'h00000000 (even count of 0xFFFFFFFF).
//     tx_last on word 8.

Source files
------------

// File: rtl/coder_out_streamer.sv
// Captures pk/sk/c/m on start and streams it LS word first; first word is valid 1 cycle after start.
// Full valid/ready backpressure (data/last held while stalled); CODER_STREAM_CHK_EN appends an XOR checksum word.
module coder_out_streamer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        sel,
   input  logic              abort,
   input  logic [6399:0]     pk_out,
   input  logic [6143:0]     sk_out,
   input  logic [6143:0]     c_out,
   input  logic [255:0]      m_out,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_last,
   output logic              busy,
   output logic              done
);
   localparam int SR_W = 6400;
   localparam logic [9:0] LAST_PK = 10'(6400 / DATA_W - 1);
   localparam logic [9:0] LAST_SK = 10'(6144 / DATA_W - 1);
   localparam logic [9:0] LAST_M  = 10'(256 / DATA_W - 1);

`ifdef CODER_STREAM_CHK_EN
   typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
   typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

   state_t          state_q, state_d;
   logic [SR_W-1:0] sr_q, sr_d;
   logic [9:0]      cnt_q, cnt_d;
   logic            done_q, done_d;
   logic [SR_W-1:0] cap;
   logic [9:0]      cap_cnt;
`ifdef CODER_STREAM_CHK_EN
   logic [DATA_W-1:0] xor_q, xor_d;
`endif

   always_comb begin
      cap     = '0;
      cap_cnt = LAST_M;
      case (sel)
         2'd0: begin cap = pk_out;           cap_cnt = LAST_PK; end
         2'd1: begin cap[6143:0] = sk_out;   cap_cnt = LAST_SK; end
         2'd2: begin cap[6143:0] = c_out;    cap_cnt = LAST_SK; end
         default: begin cap[255:0] = m_out;  cap_cnt = LAST_M;  end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef CODER_STREAM_CHK_EN
         xor_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef CODER_STREAM_CHK_EN
         xor_q   <= xor_d;
`endif
      end
   end

   // abort is checked before tx_ready in every active state so it beats a same-cycle handshake
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef CODER_STREAM_CHK_EN
      xor_d   = xor_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               sr_d    = cap;
               cnt_d   = cap_cnt;
               state_d = SEND;
`ifdef CODER_STREAM_CHK_EN
               xor_d   = '0;
`endif
            end
         end
         SEND: begin
            if (abort) begin
               state_d = IDLE;
            end else if (tx_ready) begin
               sr_d = sr_q >> DATA_W;
`ifdef CODER_STREAM_CHK_EN
               xor_d = xor_q ^ sr_q[DATA_W-1:0];
`endif
               if (cnt_q == 10'd0) begin
`ifdef CODER_STREAM_CHK_EN
                  // the checksum word rides out through the shift register's low word
                  state_d               = CHK;
                  sr_d                  = '0;
                  sr_d[DATA_W-1:0]      = xor_q ^ sr_q[DATA_W-1:0];
`else
                  state_d = IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  cnt_d = cnt_q - 10'd1;
               end
            end
         end
`ifdef CODER_STREAM_CHK_EN
         CHK: begin
            if (abort) begin
               state_d = IDLE;
            end else if (tx_ready) begin
               state_d = IDLE;
               sr_d    = '0;
               done_d  = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign tx_data  = sr_q[DATA_W-1:0];
   assign tx_valid = (state_q != IDLE);
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
`ifdef CODER_STREAM_CHK_EN
   assign tx_last  = (state_q == CHK);
`else
   assign tx_last  = (state_q == SEND) && (cnt_q == 10'd0);
`endif

endmodule
